// File: rtl/coin_payout_unit.sv
// Coin payout stage: accumulates change/refund requests into an owed amount and
// pays it out greedily (3, 2, 1) over non-empty hoppers, one acknowledged coin at a time.
module coin_payout_unit #(
  parameter int ACK_TIMEOUT = 16,
  parameter int OWED_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        change,
  input  logic [3:0]        refund,
  input  logic [2:0]        hopper_empty,
  input  logic              hopper_ack,
  input  logic              fault_clr,
  output logic [1:0]        coin_out,
  output logic              coin_valid,
  output logic              busy,
  output logic              payout_done,
  output logic              fault,
  output logic              overflow,
  output logic [OWED_W-1:0] owed
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [OWED_W-1:0] AMT_0    = {OWED_W{1'b0}};
  localparam logic [OWED_W-1:0] AMT_1    = {{(OWED_W-1){1'b0}}, 1'b1};
  localparam logic [OWED_W-1:0] AMT_2    = {{(OWED_W-2){1'b0}}, 2'd2};
  localparam logic [OWED_W-1:0] AMT_3    = {{(OWED_W-2){1'b0}}, 2'd3};
  localparam logic [OWED_W-1:0] AMT_FULL = {OWED_W{1'b1}};
  localparam logic [OWED_W:0]   OWED_MAX = {1'b0, AMT_FULL};

  // The coin code equals the denomination value, so the chosen code doubles as d.
  function automatic logic [1:0] pick_coin(input logic [OWED_W-1:0] amt,
                                           input logic [2:0]        empty);
    logic [1:0] code;
    if ((amt >= AMT_3) && !empty[2]) begin
      code = 2'b11;
    end else if ((amt >= AMT_2) && !empty[1]) begin
      code = 2'b10;
    end else if ((amt >= AMT_1) && !empty[0]) begin
      code = 2'b01;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  state_t             state_r, state_s;
  logic [OWED_W-1:0]  owed_r, owed_s;
  logic [1:0]         coin_out_r, coin_out_s;
  logic               coin_valid_r, coin_valid_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               busy_r, done_r, fault_r, overflow_r, overflow_s;
  logic [4:0]         req_sum_s;
  logic               req_s;
  logic               sat_s;
  logic [1:0]         coin_s;
  logic [OWED_W:0]    base_s, total_s;

  // Owed accumulator: subtract the acknowledged coin, add any request, saturate.
  always_comb begin
    req_sum_s = {1'b0, change} + {1'b0, refund};
    req_s     = (req_sum_s != 5'd0);
    coin_s    = pick_coin(owed_r, hopper_empty);
    if ((state_r == ST_WAIT_ACK) && hopper_ack) begin
      base_s = {1'b0, owed_r} - {{(OWED_W-1){1'b0}}, coin_out_r};
    end else begin
      base_s = {1'b0, owed_r};
    end
    total_s = base_s + {{(OWED_W-4){1'b0}}, req_sum_s};
    if (total_s > OWED_MAX) begin
      owed_s = AMT_FULL;
      sat_s  = 1'b1;
    end else begin
      owed_s = total_s[OWED_W-1:0];
      sat_s  = 1'b0;
    end
    overflow_s = overflow_r | sat_s;
  end

  // Next-state and coin handshake decode.
  always_comb begin
    state_s      = state_r;
    coin_out_s   = coin_out_r;
    coin_valid_s = coin_valid_r;
    cnt_s        = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if ((owed_r != AMT_0) || req_s) begin
          state_s = ST_SELECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (owed_r == AMT_0) begin
          state_s = ST_DONE;
        end else if (coin_s == 2'b00) begin
          state_s = ST_FAULT;
        end else begin
          state_s      = ST_WAIT_ACK;
          coin_out_s   = coin_s;
          coin_valid_s = 1'b1;
          cnt_s        = CNT_ZERO;
        end
      end
      ST_WAIT_ACK: begin
        if (hopper_ack) begin
          state_s      = ST_SELECT;
          coin_out_s   = 2'b00;
          coin_valid_s = 1'b0;
        end else if (cnt_r == CNT_LAST) begin
          // Counter reaches ACK_TIMEOUT on this edge; owed is left untouched.
          state_s      = ST_FAULT;
          coin_out_s   = 2'b00;
          coin_valid_s = 1'b0;
          cnt_s        = cnt_r + CNT_ONE;
        end else begin
          state_s = ST_WAIT_ACK;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_s = ST_SELECT;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        coin_out_s   = 2'b00;
        coin_valid_s = 1'b0;
        cnt_s        = CNT_ZERO;
      end
    endcase
  end

  // State and registered outputs; status flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      owed_r       <= AMT_0;
      coin_out_r   <= 2'b00;
      coin_valid_r <= 1'b0;
      cnt_r        <= CNT_ZERO;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      owed_r       <= owed_s;
      coin_out_r   <= coin_out_s;
      coin_valid_r <= coin_valid_s;
      cnt_r        <= cnt_s;
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
      fault_r      <= (state_s == ST_FAULT);
      overflow_r   <= overflow_s;
    end
  end

  assign coin_out    = coin_out_r;
  assign coin_valid  = coin_valid_r;
  assign busy        = busy_r;
  assign payout_done = done_r;
  assign fault       = fault_r;
  assign overflow    = overflow_r;
  assign owed        = owed_r;

endmodule

// File: tb/tb_coin_payout_unit.sv
// Directed self-checking bench for coin_payout_unit; inputs driven and outputs
// sampled on the falling edge, away from the active rising edge.
module tb_coin_payout_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] change;
  logic [3:0] refund;
  logic [2:0] hopper_empty;
  logic       hopper_ack;
  logic       fault_clr;
  logic [1:0] coin_out;
  logic       coin_valid;
  logic       busy;
  logic       payout_done;
  logic       fault;
  logic       overflow;
  logic [5:0] owed;

  int checks   = 0;
  int failures = 0;

  coin_payout_unit #(.ACK_TIMEOUT(16), .OWED_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .change       (change),
    .refund       (refund),
    .hopper_empty (hopper_empty),
    .hopper_ack   (hopper_ack),
    .fault_clr    (fault_clr),
    .coin_out     (coin_out),
    .coin_valid   (coin_valid),
    .busy         (busy),
    .payout_done  (payout_done),
    .fault        (fault),
    .overflow     (overflow),
    .owed         (owed)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_coin_out"}, 32'(coin_out), 32'd0);
    check_eq({tag, "_valid"}, 32'(coin_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(payout_done), 32'd0);
    check_eq({tag, "_fault"}, 32'(fault), 32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, "_owed"}, 32'(owed), 32'd0);
  endtask

  // Issue a one-cycle request; returns at the falling edge after it was sampled.
  task automatic request(input logic [3:0] c, input logic [3:0] r, input int exp_owed);
    change = c;
    refund = r;
    @(negedge clk);
    change = 4'd0;
    refund = 4'd0;
    check_eq("req_busy", 32'(busy), 32'd1);
    check_eq("req_owed", 32'(owed), 32'(exp_owed));
    check_eq("req_valid", 32'(coin_valid), 32'd0);
  endtask

  // Called when the DUT is in SELECT at the next rising edge: expect a coin, ack one cycle later.
  task automatic do_coin(input string tag, input int exp_code, input int exp_owed_after,
                         input logic [3:0] refund_with_ack);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(coin_valid), 32'd1);
    check_eq({tag, "_code"}, 32'(coin_out), 32'(exp_code));
    @(negedge clk);
    check_eq({tag, "_hold"}, 32'(coin_valid), 32'd1);
    check_eq({tag, "_code_hold"}, 32'(coin_out), 32'(exp_code));
    hopper_ack = 1'b1;
    refund     = refund_with_ack;
    @(negedge clk);
    hopper_ack = 1'b0;
    refund     = 4'd0;
    check_eq({tag, "_drop"}, 32'(coin_valid), 32'd0);
    check_eq({tag, "_owed"}, 32'(owed), 32'(exp_owed_after));
    check_eq({tag, "_nodone"}, 32'(payout_done), 32'd0);
  endtask

  // Called when the DUT is in SELECT with owed==0 at the next rising edge.
  task automatic expect_done(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(payout_done), 32'd1);
    check_eq({tag, "_done_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_done_fault"}, 32'(fault), 32'd0);
    @(negedge clk);
    check_eq({tag, "_done_end"}, 32'(payout_done), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int vcount;
    reset        = 1'b1;
    change       = 4'd0;
    refund       = 4'd0;
    hopper_empty = 3'b000;
    hopper_ack   = 1'b0;
    fault_clr    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");
    @(negedge clk);
    check_all_zero("idle");

    // change=4, all hoppers full: 3 then 1.
    request(4'd4, 4'd0, 4);
    do_coin("c4_a", 3, 1, 4'd0);
    do_coin("c4_b", 1, 0, 4'd0);
    expect_done("c4");

    // refund=6 with the 3-unit hopper empty: three 2-unit coins.
    hopper_empty = 3'b100;
    request(4'd0, 4'd6, 6);
    do_coin("r6_a", 2, 4, 4'd0);
    do_coin("r6_b", 2, 2, 4'd0);
    do_coin("r6_c", 2, 0, 4'd0);
    expect_done("r6");

    // change=1 with the 1-unit hopper empty: shortfall fault, then retry.
    hopper_empty = 3'b001;
    request(4'd1, 4'd0, 1);
    @(negedge clk);
    check_eq("short_fault", 32'(fault), 32'd1);
    check_eq("short_owed", 32'(owed), 32'd1);
    check_eq("short_valid", 32'(coin_valid), 32'd0);
    check_eq("short_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("short_fault_held", 32'(fault), 32'd1);
    hopper_empty = 3'b000;
    fault_clr    = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("short_clr", 32'(fault), 32'd0);
    do_coin("short_retry", 1, 0, 4'd0);
    expect_done("short");

    // change=3, no ack: coin_valid stays up for exactly ACK_TIMEOUT cycles.
    request(4'd3, 4'd0, 3);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (coin_valid) begin
        vcount++;
      end else if (vcount > 0) begin
        break;
      end
    end
    check_eq("to_valid_cycles", 32'(vcount), 32'd16);
    check_eq("to_fault", 32'(fault), 32'd1);
    check_eq("to_owed", 32'(owed), 32'd3);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("to_clr", 32'(fault), 32'd0);
    do_coin("to_retry", 3, 0, 4'd0);
    expect_done("to");

    // change=5, refund=2 lands with the first ack: 5-3+2=4, then 3 and 1.
    request(4'd5, 4'd0, 5);
    do_coin("mid_a", 3, 4, 4'd2);
    do_coin("mid_b", 3, 1, 4'd0);
    do_coin("mid_c", 1, 0, 4'd0);
    expect_done("mid");

    // Reset while waiting for an ack with owed=7 abandons the payout.
    request(4'd4, 4'd3, 7);
    @(negedge clk);
    check_eq("rst_pre_valid", 32'(coin_valid), 32'd1);
    check_eq("rst_pre_owed", 32'(owed), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("rst_mid");
    hopper_ack = 1'b1;
    repeat (3) @(negedge clk);
    hopper_ack = 1'b0;
    check_all_zero("rst_late_ack");

    // Saturation: 30+30 fits, +4 clips at 63 and sets the sticky overflow.
    hopper_empty = 3'b111;
    change = 4'd15;
    refund = 4'd15;
    @(negedge clk);
    @(negedge clk);
    change = 4'd0;
    refund = 4'd0;
    check_eq("sat_owed60", 32'(owed), 32'd60);
    check_eq("sat_no_ovf", 32'(overflow), 32'd0);
    check_eq("sat_fault", 32'(fault), 32'd1);
    change = 4'd4;
    @(negedge clk);
    change = 4'd0;
    check_eq("sat_owed63", 32'(owed), 32'd63);
    check_eq("sat_ovf", 32'(overflow), 32'd1);
    @(negedge clk);
    check_eq("sat_ovf_sticky", 32'(overflow), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hopper_empty = 3'b000;
    check_all_zero("sat_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coin_payout_unit.md
Name: coin_payout_unit

Overview:
- Downstream payout stage for the coffee vending controller.
- Consumes the one-cycle change and refund amounts the controller produces and drives a coin hopper one coin at a time. Each coin uses a valid/ack handshake.
- Uses the greedy largest-denomination-first rule (3, 2, 1) over the hoppers that are not empty.
- Reports progress and completion, and faults on hopper shortfall or on ack timeout.

Parameters:
- ACK_TIMEOUT, 16: cycles coin_valid may stay high without hopper_ack before FAULT.
- OWED_W, 6: width of the owed-amount accumulator. Saturates at 2^OWED_W-1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- change  input  4  change value; nonzero for one cycle = payout request
- refund  input  4  refund value; nonzero for one cycle = payout request
- hopper_empty  input  3  bit0=1-unit, bit1=2-unit, bit2=3-unit hopper empty
- hopper_ack  input  1  hopper accepted current coin (one-cycle pulse)
- fault_clr  input  1  operator clears fault, payout retries
- coin_out  output  2  denomination code: 01=1, 10=2, 11=3, 00=none
- coin_valid  output  1  coin_out valid, held until ack
- busy  output  1  high in any state other than IDLE
- payout_done  output  1  one-cycle pulse when owed reaches 0
- fault  output  1  shortfall or timeout; held until fault_clr
- overflow  output  1  sticky; owed saturated; cleared by reset only
- owed  output  OWED_W  amount still to pay

Behaviour:
- Reset values:
  - All outputs are registered.
  - On reset: state=IDLE, owed=0, coin_out=00, coin_valid/busy/payout_done/fault/overflow=0, timeout counter=0.
  - Reset abandons any payout in progress.
- Request:
  - Any cycle, in any state, where change+refund is nonzero adds change+refund to owed.
  - The sum is 5-bit, zero-extended, saturating. Saturation sets overflow.
- States:
  - IDLE: if owed>0, or a request arrives, go to SELECT next cycle.
  - SELECT:
    - d = largest of {3,2,1} with d<=owed and hopper for d not empty.
    - If owed==0, go to DONE.
    - If no d exists, go to FAULT.
    - Otherwise latch coin_out=code(d), set coin_valid=1, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK:
    - coin_valid and coin_out stay stable.
    - On hopper_ack: owed -= d, plus any same-cycle request. Drop coin_valid and coin_out next cycle. Go to SELECT.
    - Otherwise the counter increments. When it reaches ACK_TIMEOUT, drop coin_valid and go to FAULT with owed unchanged.
  - DONE: payout_done=1 for exactly one cycle, then IDLE. A request arriving in DONE is kept in owed and is serviced from IDLE.
  - FAULT:
    - fault=1, busy=1, coin_valid=0. Requests still accumulate.
    - On fault_clr: fault drops next cycle and the block goes to SELECT. SELECT handles the retry, or goes to DONE if owed==0.
- hopper_ack outside WAIT_ACK is ignored.
- Latency:
  - Request sampled at cycle N → busy at N+1, SELECT at N+1, coin_valid at N+2.
  - Ack at cycle M → next coin_valid no earlier than M+2.
- Denomination choice is re-evaluated in every SELECT, so a hopper emptying mid-payout changes the choice for the next coin only.
- owed never underflows, because d<=owed is guaranteed at selection.

Test Plan:
- change=4, hoppers full, ack 1 cycle after each valid:
  - coin_out 11 then 01.
  - owed goes 4→1→0.
  - payout_done pulses once, 1 cycle after the last SELECT.
  - busy drops next cycle.
- refund=6, hopper_empty=100:
  - Three coins of code 10.
  - No fault; payout_done pulses.
- change=1, hopper_empty=001:
  - fault=1, owed=1, coin_valid=0.
  - Then hopper_empty=000 and a fault_clr pulse → one coin 01, then payout_done.
- change=3, hopper_ack never asserted:
  - coin_valid high for exactly 16 cycles, then fault=1, owed=3.
  - fault_clr with ack supplied → coin 11 paid.
- change=5 while paying:
  - refund=2 arrives on the same cycle as the first ack → owed=5-3+2=4.
  - Payout continues 3, 1; single payout_done at the end.
- Reset asserted in WAIT_ACK with owed=7 → next cycle all outputs 0 and state IDLE. Later acks are ignored.
